// File: rtl/pdp_trace_buffer.sv
// pdp_trace_buffer
// Retirement-trace capture for the PDP-11 core. Each retired instruction that
// passes the class filter is written into a circular buffer. A trigger opens
// a post-trigger window; when the window closes, the buffer freezes and its
// contents drain oldest-first over a valid/ready port. The clear input acts
// as a soft reset that keeps the dropped-capture statistic.

module pdp_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int POST_W = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cap_valid,
    input  logic [DATA_W-1:0]       cap_instr,
    input  logic [DATA_W-1:0]       cap_pc,
    input  logic [DATA_W-1:0]       cap_alu,
    input  logic [1:0]              cap_class,
    input  logic [3:0]              class_mask,
    input  logic                    trigger,
    input  logic [POST_W-1:0]       post_count,
    input  logic                    clear,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [3*DATA_W+1:0]     rd_data,
    output logic [PTR_W:0]          count,
    output logic                    wrapped,
    output logic                    frozen,
    output logic [15:0]             dropped
);

    localparam int ENTRY_W = 3 * DATA_W + 2;

    // State encoding; any other value falls back to CAPTURE.
    localparam logic [1:0] ST_CAPTURE = 2'd0;
    localparam logic [1:0] ST_POST    = 2'd1;
    localparam logic [1:0] ST_FROZEN  = 2'd2;

    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]    COUNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ZERO   = PTR_W'(0);
    localparam logic [POST_W-1:0] POST_ONE   = POST_W'(1);
    localparam logic [POST_W-1:0] POST_ZERO  = POST_W'(0);
    localparam logic [15:0]       DROP_MAX   = 16'hFFFF;

    // Trace storage; contents are meaningless while count is zero, so the
    // array itself needs no reset.
    logic [ENTRY_W-1:0] mem_r [DEPTH];

    logic [1:0]         state_r,    state_s;
    logic [PTR_W-1:0]   wr_ptr_r,   wr_ptr_s;
    logic [PTR_W-1:0]   rd_ptr_r,   rd_ptr_s;
    logic [PTR_W:0]     count_r,    count_s;
    logic [PTR_W:0]     remain_r,   remain_s;
    logic               wrapped_r,  wrapped_s;
    logic [15:0]        dropped_r,  dropped_s;
    logic [POST_W-1:0]  post_cnt_r, post_cnt_s;
    logic               rd_valid_r, rd_valid_s;
    logic [ENTRY_W-1:0] rd_data_r,  rd_data_s;

    logic               capturing_s;
    logic               class_en_s;
    logic               accept_s;
    logic               reject_s;
    logic               freeze_s;
    logic               load_s;

    // Next-state logic: capture path, trigger/window control and readout.
    // rd_ptr_r always addresses the next entry to move into the output
    // register and remain_r counts entries not yet moved there, so the
    // output register refills on the same edge it is consumed.
    always_comb begin
        state_s     = state_r;
        wr_ptr_s    = wr_ptr_r;
        rd_ptr_s    = rd_ptr_r;
        count_s     = count_r;
        remain_s    = remain_r;
        wrapped_s   = wrapped_r;
        dropped_s   = dropped_r;
        post_cnt_s  = post_cnt_r;
        rd_valid_s  = rd_valid_r;
        rd_data_s   = rd_data_r;
        freeze_s    = 1'b0;
        load_s      = 1'b0;

        capturing_s = (state_r == ST_CAPTURE) || (state_r == ST_POST);
        class_en_s  = class_mask[cap_class];
        accept_s    = cap_valid & class_en_s & capturing_s;
        reject_s    = cap_valid & ~class_en_s & capturing_s;

        // Buffer occupancy: once full, each new entry replaces the oldest.
        if (accept_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
            if (count_r == FULL_COUNT) begin
                wrapped_s = 1'b1;
            end else begin
                count_s = count_r + COUNT_ONE;
            end
        end else begin
            wr_ptr_s = wr_ptr_r;
        end

        if (reject_s && (dropped_r != DROP_MAX)) begin
            dropped_s = dropped_r + 16'd1;
        end else begin
            dropped_s = dropped_r;
        end

        case (state_r)
            ST_CAPTURE: begin
                // A capture in the trigger cycle is the trigger entry itself
                // and does not count against the window.
                if (trigger) begin
                    if (post_count == POST_ZERO) begin
                        freeze_s = 1'b1;
                    end else begin
                        state_s    = ST_POST;
                        post_cnt_s = post_count;
                    end
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            ST_POST: begin
                if (accept_s) begin
                    if (post_cnt_r <= POST_ONE) begin
                        freeze_s   = 1'b1;
                        post_cnt_s = POST_ZERO;
                    end else begin
                        post_cnt_s = post_cnt_r - POST_ONE;
                    end
                end else begin
                    post_cnt_s = post_cnt_r;
                end
            end
            ST_FROZEN: begin
                load_s = ~rd_valid_r | rd_ready;
                if (load_s) begin
                    if (remain_r != COUNT_ZERO) begin
                        rd_data_s  = mem_r[rd_ptr_r];
                        rd_valid_s = 1'b1;
                        rd_ptr_s   = rd_ptr_r + PTR_ONE;
                        remain_s   = remain_r - COUNT_ONE;
                    end else begin
                        rd_valid_s = 1'b0;
                    end
                end else begin
                    rd_valid_s = rd_valid_r;
                end
            end
            default: begin
                state_s = ST_CAPTURE;
            end
        endcase

        // Entering FROZEN: point the reader at the oldest surviving entry,
        // taking this cycle's capture (if any) into account.
        if (freeze_s) begin
            state_s    = ST_FROZEN;
            rd_ptr_s   = wr_ptr_s - count_s[PTR_W-1:0];
            remain_s   = count_s;
            rd_valid_s = 1'b0;
        end else begin
            rd_ptr_s = rd_ptr_s;
        end
    end

    // Control registers: hard reset clears everything, clear keeps dropped.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r    <= ST_CAPTURE;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= COUNT_ZERO;
            remain_r   <= COUNT_ZERO;
            wrapped_r  <= 1'b0;
            dropped_r  <= 16'd0;
            post_cnt_r <= POST_ZERO;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {ENTRY_W{1'b0}};
        end else if (clear) begin
            state_r    <= ST_CAPTURE;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= COUNT_ZERO;
            remain_r   <= COUNT_ZERO;
            wrapped_r  <= 1'b0;
            dropped_r  <= dropped_r;
            post_cnt_r <= POST_ZERO;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {ENTRY_W{1'b0}};
        end else begin
            state_r    <= state_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            remain_r   <= remain_s;
            wrapped_r  <= wrapped_s;
            dropped_r  <= dropped_s;
            post_cnt_r <= post_cnt_s;
            rd_valid_r <= rd_valid_s;
            rd_data_r  <= rd_data_s;
        end
    end

    // Trace write port: a capture in a reset or clear cycle is discarded.
    always_ff @(posedge clock) begin
        if (accept_s && reset_n && !clear) begin
            mem_r[wr_ptr_r] <= {cap_class, cap_pc, cap_instr, cap_alu};
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign count    = count_r;
    assign wrapped  = wrapped_r;
    assign frozen   = (state_r == ST_FROZEN);
    assign dropped  = dropped_r;

endmodule

// File: tb/tb_pdp_trace_buffer.sv
// Bench for pdp_trace_buffer (DEPTH=8). A queue-based reference model tracks
// the stored trace, freeze state and statistics; directed scenarios and a
// randomized phase are compared against it every cycle.

module tb_pdp_trace_buffer;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;
    localparam int POST_W = 8;
    localparam int PTR_W  = 3;
    localparam int EW     = 3 * DATA_W + 2;

    localparam int M_CAP  = 0;
    localparam int M_POST = 1;
    localparam int M_FRZ  = 2;

    logic              clock;
    logic              reset_n;
    logic              cap_valid;
    logic [15:0]       cap_instr;
    logic [15:0]       cap_pc;
    logic [15:0]       cap_alu;
    logic [1:0]        cap_class;
    logic [3:0]        class_mask;
    logic              trigger;
    logic [7:0]        post_count;
    logic              clear;
    logic              rd_valid;
    logic              rd_ready;
    logic [EW-1:0]     rd_data;
    logic [PTR_W:0]    count;
    logic              wrapped;
    logic              frozen;
    logic [15:0]       dropped;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    logic [EW-1:0] q[$];
    logic [EW-1:0] rdq[$];
    int            mode;
    int            post_left;
    logic          m_wrapped;
    int            m_dropped;

    pdp_trace_buffer #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .POST_W(POST_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cap_valid (cap_valid),
        .cap_instr (cap_instr),
        .cap_pc    (cap_pc),
        .cap_alu   (cap_alu),
        .cap_class (cap_class),
        .class_mask(class_mask),
        .trigger   (trigger),
        .post_count(post_count),
        .clear     (clear),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .count     (count),
        .wrapped   (wrapped),
        .frozen    (frozen),
        .dropped   (dropped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic acc;
        if (!reset_n || clear) begin
            q.delete();
            rdq.delete();
            mode      = M_CAP;
            post_left = 0;
            m_wrapped = 1'b0;
            if (!reset_n) m_dropped = 0;
        end else if (mode != M_FRZ) begin
            acc = cap_valid && class_mask[cap_class];
            if (acc) begin
                q.push_back({cap_class, cap_pc, cap_instr, cap_alu});
                if (q.size() > DEPTH) begin
                    void'(q.pop_front());
                    m_wrapped = 1'b1;
                end
            end else if (cap_valid && m_dropped < 65535) begin
                m_dropped++;
            end
            if (mode == M_CAP) begin
                if (trigger) begin
                    if (post_count == 8'd0) mode = M_FRZ;
                    else begin
                        mode      = M_POST;
                        post_left = int'(post_count);
                    end
                end
            end else if (acc) begin
                post_left--;
                if (post_left == 0) mode = M_FRZ;
            end
            if (mode == M_FRZ) rdq = q;
        end
    endtask

    // One clock: model follows the edge, DUT status compared 1 time unit later.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("frozen",  {63'd0, frozen}, {63'd0, mode == M_FRZ});
        check("count",   {60'd0, count}, 64'(q.size()));
        check("wrapped", {63'd0, wrapped}, {63'd0, m_wrapped});
        check("dropped", {48'd0, dropped}, 64'(m_dropped));
    endtask

    task automatic cap(input logic [15:0] pc, input logic [1:0] cls,
                       input logic trig, input logic [7:0] pcnt);
        cap_valid  = 1'b1;
        cap_pc     = pc;
        cap_class  = cls;
        cap_instr  = 16'($urandom);
        cap_alu    = 16'($urandom);
        trigger    = trig;
        post_count = pcnt;
        step();
        cap_valid  = 1'b0;
        trigger    = 1'b0;
    endtask

    // Consume up to 'limit' entries. rmode 0: always ready, 1: 1,0,0,1 pattern,
    // otherwise random ready.
    task automatic drain(input int limit, input int rmode);
        int         got;
        int         want;
        int         cyc;
        logic       rdy;
        logic       stalled;
        logic [3:0] pat;
        pat     = 4'b1001;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        want    = (rdq.size() < limit) ? rdq.size() : limit;
        while (got < want && cyc < 200) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 4];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rd_ready = rdy;
            if (stalled) check("stall_valid", {63'd0, rd_valid}, 64'd1);
            if (rd_valid === 1'b1) begin
                check("rd_data", 64'(rd_data), 64'(rdq[0]));
                stalled = !rdy;
                if (rdy) begin
                    void'(rdq.pop_front());
                    got++;
                end
            end else begin
                stalled = 1'b0;
            end
            step();
            cyc++;
        end
        rd_ready = 1'b0;
        check("drain_count", 64'(got), 64'(want));
    endtask

    initial begin
        reset_n    = 1'b0;
        cap_valid  = 1'b1;
        cap_instr  = 16'h1234;
        cap_pc     = 16'h0100;
        cap_alu    = 16'h5555;
        cap_class  = 2'd1;
        class_mask = 4'hF;
        trigger    = 1'b1;
        post_count = 8'd0;
        clear      = 1'b0;
        rd_ready   = 1'b1;
        mode       = M_CAP;
        post_left  = 0;
        m_wrapped  = 1'b0;
        m_dropped  = 0;

        // Reset state.
        step();
        step();
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_rd_data",  64'(rd_data), 64'd0);
        cap_valid = 1'b0;
        trigger   = 1'b0;
        rd_ready  = 1'b0;
        reset_n   = 1'b1;
        step();

        // Five captures, trigger with zero window on the fifth.
        for (int i = 0; i < 5; i++) cap(16'(2 * i), 2'(i), i == 4, 8'd0);
        check("t1_count", {60'd0, count}, 64'd5);
        drain(100, 0);
        check("t1_empty", {63'd0, rd_valid}, 64'd0);
        step();
        check("t1_empty2", {63'd0, rd_valid}, 64'd0);

        // Overflow: eleven captures then a bare trigger; stalled drain.
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 11; i++) cap(16'(2 * i), 2'($urandom), 1'b0, 8'd0);
        trigger = 1'b1; post_count = 8'd0; step(); trigger = 1'b0;
        check("t2_count", {60'd0, count}, 64'd8);
        check("t2_wrapped", {63'd0, wrapped}, 64'd1);
        drain(100, 1);
        check("t2_empty", {63'd0, rd_valid}, 64'd0);

        // Post-trigger window of three after trigger entry A.
        clear = 1'b1; step(); clear = 1'b0;
        cap(16'h0A00, 2'd0, 1'b0, 8'd0);
        cap(16'h0A0A, 2'd1, 1'b1, 8'd3);
        cap(16'h0B0B, 2'd2, 1'b1, 8'd7);
        step();
        cap(16'h0C0C, 2'd3, 1'b0, 8'd0);
        check("t3_not_yet", {63'd0, frozen}, 64'd0);
        cap(16'h0D0D, 2'd0, 1'b0, 8'd0);
        check("t3_frozen", {63'd0, frozen}, 64'd1);
        class_mask = 4'b0000;
        cap(16'h0E0E, 2'd1, 1'b1, 8'd0);
        class_mask = 4'hF;
        drain(100, 2);

        // Class filter: alternate class 3 and class 0 with class 3 masked.
        clear = 1'b1; step(); clear = 1'b0;
        class_mask = 4'b0111;
        for (int i = 0; i < 6; i++) cap(16'(16'h0200 + i), (i % 2 == 0) ? 2'd3 : 2'd0, 1'b0, 8'd0);
        check("t4_dropped", {48'd0, dropped}, 64'd3);
        trigger = 1'b1; step(); trigger = 1'b0;
        drain(100, 0);

        // Randomized rounds.
        for (int r = 0; r < 6; r++) begin
            clear = 1'b1; step(); clear = 1'b0;
            class_mask = 4'($urandom);
            for (int c = 0; c < 60 && mode != M_FRZ; c++) begin
                cap_valid  = 1'($urandom);
                cap_class  = 2'($urandom);
                cap_pc     = 16'($urandom);
                cap_instr  = 16'($urandom);
                cap_alu    = 16'($urandom);
                trigger    = ($urandom_range(0, 9) == 0);
                post_count = 8'($urandom_range(0, 4));
                step();
            end
            cap_valid = 1'($urandom);
            trigger   = 1'($urandom);
            drain(100, 2);
            check("rnd_empty", {63'd0, rd_valid}, 64'd0);
            step();
            cap_valid = 1'b0;
            trigger   = 1'b0;
        end

        // Clear beats trigger and capture in the same cycle.
        clear = 1'b1; step(); clear = 1'b0;
        class_mask = 4'hF;
        cap(16'h0300, 2'd0, 1'b0, 8'd0);
        cap(16'h0302, 2'd1, 1'b0, 8'd0);
        clear = 1'b1;
        cap(16'h0304, 2'd2, 1'b1, 8'd0);
        clear = 1'b0;
        check("t6_count", {60'd0, count}, 64'd0);
        check("t6_frozen", {63'd0, frozen}, 64'd0);
        cap(16'h0306, 2'd3, 1'b0, 8'd0);
        check("t6_recapture", {60'd0, count}, 64'd1);

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) cap(16'(16'h0400 + i), 2'd0, i == 2, 8'd0);
        drain(2, 0);
        reset_n = 1'b0; step(); reset_n = 1'b1;
        check("t7_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("t7_rd_data", 64'(rd_data), 64'd0);
        check("t7_dropped", {48'd0, dropped}, 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
